// File: rtl/wb_line_cache.sv
// Direct-mapped, write-back, write-allocate line cache: Wishbone slave to the CPU,
// Wishbone master to memory, one 128-bit line per set.
module wb_line_cache #(
  parameter int unsigned IDX_BITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  // cpu_to_cache (slave)
  input  logic [15:0]  cpu_adr_i,
  input  logic [127:0] cpu_dat_m_i,
  output logic [127:0] cpu_dat_s_o,
  input  logic [15:0]  cpu_sel_i,
  input  logic         cpu_we_i,
  input  logic         cpu_cyc_i,
  input  logic         cpu_stb_i,
  output logic         cpu_ack_o,
  // cache_to_mem (master)
  output logic [15:0]  mem_adr_o,
  output logic [127:0] mem_dat_m_o,
  input  logic [127:0] mem_dat_s_i,
  output logic [15:0]  mem_sel_o,
  output logic         mem_we_o,
  output logic         mem_cyc_o,
  output logic         mem_stb_o,
  input  logic         mem_ack_i
);

  localparam int unsigned TagBits = 12 - IDX_BITS;
  localparam int unsigned Sets    = 1 << IDX_BITS;

  typedef enum logic [1:0] {StIdle, StLookup, StWriteback, StFill} state_e;

  state_e              state_q;
  logic [Sets-1:0]     valid_q, dirty_q;
  logic [TagBits-1:0]  tag_q  [Sets];
  logic [127:0]        line_q [Sets];

  logic [11:0]         req_line_q;
  logic [15:0]         req_sel_q;
  logic                req_we_q;
  logic [127:0]        req_dat_q;

  logic                cpu_ack_q;
  logic [127:0]        cpu_dat_s_q;
  logic [15:0]         mem_adr_q, mem_sel_q;
  logic [127:0]        mem_dat_m_q;
  logic                mem_we_q, mem_cyc_q, mem_stb_q;

  logic [IDX_BITS-1:0] in_idx, req_idx;
  logic [TagBits-1:0]  in_tag, req_tag;
  logic                hit_in;
  logic [127:0]        merged;
  logic [15:0]         wb_adr, fill_adr;
  logic                unused_adr_lo;

  assign unused_adr_lo = ^cpu_adr_i[3:0];

  assign in_idx  = cpu_adr_i[4 +: IDX_BITS];
  assign in_tag  = cpu_adr_i[15 -: TagBits];
  assign req_idx = req_line_q[IDX_BITS-1:0];
  assign req_tag = req_line_q[11 -: TagBits];
  assign hit_in  = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  assign wb_adr   = {tag_q[req_idx], req_idx, 4'b0000};
  assign fill_adr = {req_line_q, 4'b0000};

  always_comb begin
    merged = line_q[req_idx];
    for (int i = 0; i < 16; i++) begin
      if (req_sel_q[i]) merged[8*i +: 8] = req_dat_q[8*i +: 8];
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (state_q == StFill && mem_ack_i) begin
      line_q[req_idx] <= mem_dat_s_i;
      tag_q[req_idx]  <= req_tag;
    end else if (state_q == StLookup && cpu_ack_q && req_we_q) begin
      line_q[req_idx] <= merged;
    end
  end

  // Hit is resolved on entry to StLookup so that ACK and DAT_S are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_line_q  <= '0;
      req_sel_q   <= '0;
      req_we_q    <= 1'b0;
      req_dat_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_dat_s_q <= '0;
      mem_adr_q   <= '0;
      mem_sel_q   <= '0;
      mem_dat_m_q <= '0;
      mem_we_q    <= 1'b0;
      mem_cyc_q   <= 1'b0;
      mem_stb_q   <= 1'b0;
    end else begin
      cpu_ack_q   <= 1'b0;
      cpu_dat_s_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (cpu_cyc_i && cpu_stb_i) begin
            req_line_q <= cpu_adr_i[15:4];
            req_sel_q  <= cpu_sel_i;
            req_we_q   <= cpu_we_i;
            req_dat_q  <= cpu_dat_m_i;
            cpu_ack_q  <= hit_in;
            if (hit_in) cpu_dat_s_q <= line_q[in_idx];
            state_q    <= StLookup;
          end
        end
        StLookup: begin
          if (cpu_ack_q) begin
            if (req_we_q) dirty_q[req_idx] <= 1'b1;
            state_q <= StIdle;
          end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
            mem_cyc_q   <= 1'b1;
            mem_stb_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_sel_q   <= '1;
            mem_adr_q   <= wb_adr;
            mem_dat_m_q <= line_q[req_idx];
            state_q     <= StWriteback;
          end else begin
            mem_cyc_q <= 1'b1;
            mem_stb_q <= 1'b1;
            mem_we_q  <= 1'b0;
            mem_sel_q <= '1;
            mem_adr_q <= fill_adr;
            state_q   <= StFill;
          end
        end
        StWriteback: begin
          if (mem_ack_i) begin
            dirty_q[req_idx] <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= fill_adr;
            mem_dat_m_q <= '0;
            state_q     <= StFill;
          end
        end
        StFill: begin
          if (mem_ack_i) begin
            valid_q[req_idx] <= 1'b1;
            dirty_q[req_idx] <= 1'b0;
            cpu_ack_q   <= 1'b1;
            cpu_dat_s_q <= mem_dat_s_i;
            mem_cyc_q   <= 1'b0;
            mem_stb_q   <= 1'b0;
            mem_sel_q   <= '0;
            mem_adr_q   <= '0;
            state_q     <= StLookup;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_dat_s_o = cpu_dat_s_q;
  assign mem_adr_o   = mem_adr_q;
  assign mem_sel_o   = mem_sel_q;
  assign mem_dat_m_o = mem_dat_m_q;
  assign mem_we_o    = mem_we_q;
  assign mem_cyc_o   = mem_cyc_q;
  assign mem_stb_o   = mem_stb_q;

endmodule
